// File: rtl/avl_bus_rsp_router.sv
// avl_bus_rsp_router
// Read-response router for the shared Avalon-MM bus. The master index granted
// for each accepted read command is stored in an in-order tag FIFO. One tag is
// popped per slave readdatavalid beat, and that beat is steered back to the
// owning master as a registered one-hot readdatavalid.
//
// Ports:
//   clk, rst_n       single rising-edge clock, synchronous active-low reset
//   req_valid        read command accepted by the slave this cycle
//   req_index        granted master index for that command
//   req_ready        tag FIFO has room; the arbiter must hold reads while low
//   s_readdata       slave read data
//   s_readdatavalid  slave response beat
//   m_readdata       registered read data, broadcast to all masters
//   m_readdatavalid  registered one-hot valid, one bit per master
//   pending_cnt      number of outstanding reads
//   err_status       sticky: [0] beat with no pending tag, [1] command dropped while full
module avl_bus_rsp_router #(
  parameter int unsigned MASTER_NUM  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PENDING = 8,
  localparam int unsigned IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int unsigned PW = $clog2(MAX_PENDING),
  localparam int unsigned CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [IW-1:0]         req_index,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdatavalid,
  output logic [DATA_WIDTH-1:0] m_readdata,
  output logic [MASTER_NUM-1:0] m_readdatavalid,
  output logic [CW-1:0]         pending_cnt,
  output logic [1:0]            err_status
);

  logic [IW-1:0]         tags [MAX_PENDING];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  unexpected;
  logic [IW-1:0]         tag;
  logic [MASTER_NUM-1:0] onehot;

  // Ready comes from the registered count only: a pop in the same cycle does
  // not make room for a push, so a command arriving while full is dropped.
  assign req_ready  = (pending_cnt != CW'(MAX_PENDING));
  assign push       = req_valid && req_ready;
  assign drop       = req_valid && !req_ready;
  assign pop        = s_readdatavalid && (pending_cnt != '0);
  assign unexpected = s_readdatavalid && (pending_cnt == '0);
  assign tag        = tags[rp];

  // Indices at or above MASTER_NUM match no bit and decode to all-zero.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (tag == IW'(i)) onehot[i] = 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) tags[wp] <= req_index;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp              <= '0;
      rp              <= '0;
      pending_cnt     <= '0;
      m_readdatavalid <= '0;
      m_readdata      <= '0;
      err_status      <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   pending_cnt <= pending_cnt + CW'(1);
        2'b01:   pending_cnt <= pending_cnt - CW'(1);
        default: pending_cnt <= pending_cnt;
      endcase
      m_readdatavalid <= pop ? onehot : '0;
      if (s_readdatavalid) m_readdata <= s_readdata;
      err_status <= err_status | {drop, unexpected};
    end
  end

endmodule

// File: tb/tb_avl_bus_rsp_router.sv
module tb_avl_bus_rsp_router;

  localparam int unsigned MN   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_index = '0;
  logic          req_ready;
  logic [DW-1:0] s_readdata = '0;
  logic          s_readdatavalid = 1'b0;
  logic [DW-1:0] m_readdata;
  logic [MN-1:0] m_readdatavalid;
  logic [2:0]    pending_cnt;
  logic [1:0]    err_status;

  avl_bus_rsp_router #(
    .MASTER_NUM (MN),
    .DATA_WIDTH (DW),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_index      (req_index),
    .req_ready      (req_ready),
    .s_readdata     (s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pending_cnt    (pending_cnt),
    .err_status     (err_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MN-1:0] rdv;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    bit            rst;
    bit            rv;
    logic [2:0]    idx;
    bit            sv;
    logic [DW-1:0] d;
    logic [2:0]    cnt;
    logic [MN-1:0] rdv;
    logic [1:0]    err;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [2:0]    tq[$];
  logic [1:0]    merr = '0;
  logic [DW-1:0] mdata = '0;
  exp_t          sbq[$];
  vec_t          vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    s_readdatavalid = 1'b0;
    tq.delete();
    sbq.delete();
    merr = '0;
    mdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_rdv", 64'(m_readdatavalid), 64'd0);
    chk("rst_data", 64'(m_readdata), 64'd0);
    chk("rst_cnt", 64'(pending_cnt), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_err", 64'(err_status), 64'd0);
  endtask

  // Drive one cycle, advance the model, push the expected beat to the
  // scoreboard, then pop and compare after the edge.
  task automatic tick(input bit rv, input logic [2:0] idx, input bit sv, input logic [DW-1:0] d);
    exp_t e;
    bit   ready;
    bit   pop;
    req_valid = rv;
    req_index = idx;
    s_readdatavalid = sv;
    s_readdata = d;
    ready = (tq.size() != MAXP);
    pop = sv && (tq.size() != 0);
    e.rdv = pop ? (MN'(1) << tq[0]) : '0;
    if (sv) mdata = d;
    e.data = mdata;
    if (rv && !ready) merr[1] = 1'b1;
    if (sv && tq.size() == 0) merr[0] = 1'b1;
    if (pop) void'(tq.pop_front());
    if (rv && ready) tq.push_back(idx);
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    s_readdatavalid = 1'b0;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("m_readdatavalid", 64'(m_readdatavalid), 64'(e.rdv));
      chk("m_readdata", 64'(m_readdata), 64'(e.data));
    end
    chk("pending_cnt", 64'(pending_cnt), 64'(tq.size()));
    chk("req_ready", 64'(req_ready), 64'(tq.size() != MAXP));
    chk("err_status", 64'(err_status), 64'(merr));
  endtask

  function automatic vec_t V(bit rst, bit rv, logic [2:0] idx, bit sv, logic [DW-1:0] d,
                             logic [2:0] cnt, logic [MN-1:0] rdv, logic [1:0] err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.idx = idx; v.sv = sv; v.d = d;
    v.cnt = cnt; v.rdv = rdv; v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Single read, then full/overflow with pop+push while full
    vecs.push_back(V(1, 0, 0, 0, 32'h0,        0, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 5, 0, 32'h0,        1, 8'h00, 2'b00));
    vecs.push_back(V(0, 0, 0, 0, 32'h0,        1, 8'h00, 2'b00));
    vecs.push_back(V(0, 0, 0, 0, 32'h0,        1, 8'h00, 2'b00));
    vecs.push_back(V(0, 0, 0, 1, 32'hDEADBEEF, 0, 8'h20, 2'b00));
    vecs.push_back(V(0, 0, 0, 0, 32'h0,        0, 8'h00, 2'b00));
    vecs.push_back(V(1, 0, 0, 0, 32'h0,        0, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 2, 0, 32'h0,        1, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 7, 0, 32'h0,        2, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 0, 0, 32'h0,        3, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 4, 0, 32'h0,        4, 8'h00, 2'b00));
    vecs.push_back(V(0, 1, 1, 0, 32'h0,        4, 8'h00, 2'b10));
    vecs.push_back(V(0, 1, 3, 1, 32'hA1,       3, 8'h04, 2'b10));
    vecs.push_back(V(0, 0, 0, 0, 32'h0,        3, 8'h00, 2'b10));
    vecs.push_back(V(0, 0, 0, 1, 32'hB2,       2, 8'h80, 2'b10));
    vecs.push_back(V(0, 0, 0, 1, 32'hC3,       1, 8'h01, 2'b10));
    vecs.push_back(V(0, 0, 0, 1, 32'hD4,       0, 8'h10, 2'b10));

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        tick(vecs[i].rv, vecs[i].idx, vecs[i].sv, vecs[i].d);
        chk("vec_cnt", 64'(pending_cnt), 64'(vecs[i].cnt));
        chk("vec_ready", 64'(req_ready), 64'(vecs[i].cnt != 3'd4));
        chk("vec_rdv", 64'(m_readdatavalid), 64'(vecs[i].rdv));
        chk("vec_err", 64'(err_status), 64'(vecs[i].err));
        if (vecs[i].sv) chk("vec_data", 64'(m_readdata), 64'(vecs[i].d));
      end
    end

    // Ordering with pointer wrap, three rounds
    do_reset();
    for (int r = 0; r < 3; r++) begin
      tick(1, 3'd2, 0, '0);
      tick(1, 3'd7, 0, '0);
      tick(1, 3'd0, 0, '0);
      tick(1, 3'd4, 0, '0);
      tick(0, 3'd0, 1, 32'h11);
      chk("wrap_p0", 64'(m_readdatavalid), 64'h04);
      tick(0, 3'd0, 1, 32'h22);
      chk("wrap_p1", 64'(m_readdatavalid), 64'h80);
      tick(0, 3'd0, 1, 32'h33);
      chk("wrap_p2", 64'(m_readdatavalid), 64'h01);
      tick(0, 3'd0, 1, 32'h44);
      chk("wrap_p3", 64'(m_readdatavalid), 64'h10);
      tick(0, 3'd0, 0, '0);
    end

    // Unexpected beats, alone and with a simultaneous push
    do_reset();
    tick(0, 3'd0, 1, 32'h55);
    chk("unexp_rdv", 64'(m_readdatavalid), 64'h0);
    chk("unexp_err", 64'(err_status), 64'h1);
    do_reset();
    tick(1, 3'd1, 1, 32'h55);
    chk("unexp_push_rdv", 64'(m_readdatavalid), 64'h0);
    chk("unexp_push_cnt", 64'(pending_cnt), 64'd1);
    tick(0, 3'd0, 1, 32'h66);
    chk("unexp_next_rdv", 64'(m_readdatavalid), 64'h02);
    chk("unexp_next_err", 64'(err_status), 64'h1);

    // Steady push+pop at depth 2
    do_reset();
    tick(1, 3'd3, 0, '0);
    tick(1, 3'd6, 0, '0);
    for (int i = 0; i < 10; i++) begin
      tick(1, 3'(i), 1, 32'(32'h100 + i));
      chk("pp_cnt", 64'(pending_cnt), 64'd2);
    end
    tick(0, 3'd0, 1, 32'h200);
    tick(0, 3'd0, 1, 32'h201);
    chk("pp_err", 64'(err_status), 64'h0);

    // Mid-operation reset
    tick(1, 3'd1, 0, '0);
    tick(1, 3'd2, 0, '0);
    tick(1, 3'd3, 1, 32'h77);
    do_reset();
    tick(0, 3'd0, 1, 32'h88);
    chk("post_rst_rdv", 64'(m_readdatavalid), 64'h0);
    chk("post_rst_err", 64'(err_status), 64'h1);
    tick(0, 3'd0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
